// File: rtl/divider_8b.sv
// Sequential unsigned restoring divider: 8-bit dividend / 4-bit divisor, one
// quotient bit per cycle MSB first, valid/ready handshakes on both sides.
module divider_8b (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] dividend,
  input  logic [3:0] divisor,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e     state_q, state_d;
  logic [7:0] dvd_q, dvd_d;
  logic [3:0] dvs_q, dvs_d;
  // Partial remainder is always < divisor after a step, so its 5th bit is
  // only ever live inside the trial value and is not stored.
  logic [3:0] prem_q, prem_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] quot_q, quot_d;
  logic [7:0] q_out_q, q_out_d;
  logic [3:0] r_out_q, r_out_d;
  logic       dbz_q, dbz_d;

  logic [4:0] trial;
  logic       fits;

  always_comb begin
    trial     = {prem_q, dvd_q[cnt_q]};
    fits      = (trial >= {1'b0, dvs_q});
    state_d   = state_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    prem_d    = prem_q;
    cnt_d     = cnt_q;
    quot_d    = quot_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    dbz_d     = dbz_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          dvd_d  = dividend;
          dvs_d  = divisor;
          prem_d = 4'd0;
          cnt_d  = 3'd7;
          quot_d = 8'd0;
          if (divisor == 4'd0) begin
            state_d = DONE;
            q_out_d = 8'hFF;
            r_out_d = 4'hF;
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // When the trial fits, trial - divisor < divisor <= 15, so 4 bits suffice.
        prem_d        = fits ? (trial[3:0] - dvs_q) : trial[3:0];
        quot_d[cnt_q] = fits;
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          q_out_d = quot_d;
          r_out_d = prem_d;
          dbz_d   = 1'b0;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dvd_q   <= 8'd0;
      dvs_q   <= 4'd0;
      prem_q  <= 4'd0;
      cnt_q   <= 3'd0;
      quot_q  <= 8'd0;
      q_out_q <= 8'd0;
      r_out_q <= 4'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      q_out_q <= q_out_d;
      r_out_q <= r_out_d;
      dbz_q   <= dbz_d;
    end
  end

  assign quotient    = q_out_q;
  assign remainder   = r_out_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_divider_8b.sv
// Self-checking bench for divider_8b: directed cases, mid-operation reset,
// random ops with output stalls, and all nonzero-divisor pairs back-to-back.
module tb_divider_8b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] dividend = 8'd0;
  logic [3:0] divisor = 4'd0;
  logic       in_ready, out_valid, div_by_zero;
  logic [7:0] quotient;
  logic [3:0] remainder;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  divider_8b dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one operation and waits for out_valid. lat counts rising edges
  // after the accepting edge until out_valid is seen (-1 on timeout); acc is
  // the cycle count just before the accepting edge.
  task automatic run_op(input int a, input int b,
                        output logic [7:0] q, output logic [3:0] r,
                        output logic z, output int lat, output int acc);
    int n;
    @(negedge clk);
    dividend = a[7:0];
    divisor  = b[3:0];
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin @(negedge clk); n++; end
    acc = cyc;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!out_valid) lat = -1;
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic take();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold got rdy=%b vld=%b q=%h r=%h z=%b required rdy=1 vld=0 q=00 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL reset_release got rdy=%b vld=%b q=%h r=%h z=%b required rdy=1 vld=0 q=00 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
  endtask

  task automatic test_basic();
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc;
    run_op(225, 15, q, r, z, lat, acc);
    checks++;
    if (lat !== 8) begin errors++; $display("FAIL basic_latency got=%0d required=8", lat); end
    checks++;
    if ({q, r, z} !== {8'd15, 4'd0, 1'b0}) begin
      errors++; $display("FAIL basic_result got q=%0d r=%0d z=%b required q=15 r=0 z=0", q, r, z);
    end
    take();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_turnaround got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
  endtask

  task automatic test_stall();
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc, seen;
    run_op(200, 7, q, r, z, lat, acc);
    checks++;
    if ({q, r, z} !== {8'd28, 4'd4, 1'b0} || lat !== 8) begin
      errors++; $display("FAIL stall_result got q=%0d r=%0d z=%b lat=%0d required q=28 r=4 z=0 lat=8", q, r, z, lat);
    end
    for (int i = 0; i < 5; i++) begin
      // Pulse unrelated work while the result waits; it must be ignored.
      in_valid = i[0] ? 1'b0 : 1'b1;
      dividend = 8'd9;
      divisor  = 4'd2;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b0, 1'b1, 8'd28, 4'd4, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold[%0d] got rdy=%b vld=%b q=%0d r=%0d z=%b required rdy=0 vld=1 q=28 r=4 z=0",
                 i, in_ready, out_valid, quotient, remainder, div_by_zero);
      end
    end
    in_valid = 1'b0;
    take();
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++; $display("FAIL stall_release got rdy=%b vld=%b required rdy=1 vld=0", in_ready, out_valid);
    end
    seen = 0;
    repeat (10) begin @(negedge clk); if (out_valid) seen = 1; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL stall_ghost_op got out_valid seen=%0d required 0", seen); end
  endtask

  task automatic test_div_zero();
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc;
    run_op(77, 0, q, r, z, lat, acc);
    checks++;
    if (lat !== 0) begin errors++; $display("FAIL dbz_latency got=%0d required=0", lat); end
    checks++;
    if ({q, r, z} !== {8'hFF, 4'hF, 1'b1}) begin
      errors++; $display("FAIL dbz_result got q=%h r=%h z=%b required q=ff r=f z=1", q, r, z);
    end
    take();
  endtask

  task automatic test_boundary();
    int ta[3] = '{255, 0, 14};
    int tb[3] = '{1, 9, 15};
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], q, r, z, lat, acc);
      checks++;
      if (q !== 8'(ta[i] / tb[i]) || r !== 4'(ta[i] % tb[i]) || z !== 1'b0 || lat !== 8) begin
        errors++;
        $display("FAIL boundary %0d/%0d got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=0 lat=8",
                 ta[i], tb[i], q, r, z, lat, ta[i] / tb[i], ta[i] % tb[i]);
      end
      take();
    end
  endtask

  task automatic test_reset_mid_calc();
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc, seen;
    @(negedge clk);
    dividend = 8'd100;
    divisor  = 4'd3;
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b required=1", in_ready); end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, quotient, remainder, div_by_zero} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_clear got rdy=%b vld=%b q=%h r=%h z=%b required rdy=1 vld=0 q=00 r=0 z=0",
               in_ready, out_valid, quotient, remainder, div_by_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin @(negedge clk); if (out_valid) seen = 1; end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_no_result got seen=%0d required 0", seen); end
    run_op(100, 3, q, r, z, lat, acc);
    checks++;
    if ({q, r, z} !== {8'd33, 4'd1, 1'b0} || lat !== 8) begin
      errors++; $display("FAIL midrst_redo got q=%0d r=%0d z=%b lat=%0d required q=33 r=1 z=0 lat=8", q, r, z, lat);
    end
    take();
  endtask

  task automatic test_random();
    logic [7:0] q, eq; logic [3:0] r, er; logic z, ez; int lat, acc, a, b, stall;
    for (int n = 0; n < 150; n++) begin
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 15));
      eq = (b == 0) ? 8'hFF : 8'(a / b);
      er = (b == 0) ? 4'hF : 4'(a % b);
      ez = (b == 0);
      run_op(a, b, q, r, z, lat, acc);
      checks++;
      if ({q, r, z} !== {eq, er, ez} || lat !== ((b == 0) ? 0 : 8)) begin
        errors++;
        $display("FAIL random %0d/%0d got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=%b lat=%0d",
                 a, b, q, r, z, lat, eq, er, ez, (b == 0) ? 0 : 8);
      end
      stall = int'($urandom_range(0, 3));
      repeat (stall) @(negedge clk);
      checks++;
      if ({out_valid, quotient, remainder, div_by_zero} !== {1'b1, eq, er, ez}) begin
        errors++;
        $display("FAIL random_stall %0d/%0d got vld=%b q=%0d r=%0d z=%b required vld=1 q=%0d r=%0d z=%b",
                 a, b, out_valid, quotient, remainder, div_by_zero, eq, er, ez);
      end
      take();
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] q; logic [3:0] r; logic z; int lat, acc, prev;
    prev = -1;
    out_ready = 1'b1;
    for (int a = 0; a < 256; a++) begin
      for (int b = 1; b < 16; b++) begin
        run_op(a, b, q, r, z, lat, acc);
        checks++;
        if (q !== 8'(a / b) || r !== 4'(a % b) || z !== 1'b0 || lat !== 8) begin
          errors++;
          $display("FAIL exh %0d/%0d got q=%0d r=%0d z=%b lat=%0d required q=%0d r=%0d z=0 lat=8",
                   a, b, q, r, z, lat, a / b, a % b);
        end
        checks++;
        if (int'(q) * b + int'(r) != a || int'(r) >= b) begin
          errors++; $display("FAIL exh_invariant %0d/%0d got q=%0d r=%0d", a, b, q, r);
        end
        if (prev >= 0) begin
          checks++;
          if (acc - prev != 10) begin
            errors++; $display("FAIL exh_period %0d/%0d got=%0d required=10", a, b, acc - prev);
          end
        end
        prev = acc;
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_div_zero();
    test_boundary();
    test_reset_mid_calc();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
